// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with optional return-address stack
// Optional RAS enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h80),
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             call,
  input  logic             ret,
  input  logic             exc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic [4:0]       ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign,
  output logic             ras_underflow
);

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = STEP_W - WIDTH'(1);

  logic             accept;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] load_tgt;
  logic             ret_hit;
  logic [WIDTH-1:0] ras_top;
  logic             underflow_d;
  logic             misalign_q;
  logic             underflow_q;
  logic [WIDTH-1:0] pc_q;

  // exc alone may advance the PC while stalled; everything else needs enable
  assign accept   = enable & ~exc;
  assign seq_pc   = pc_q + STEP_W;
  assign load_tgt = in & ~LOW_MASK;

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [4:0]       cnt_q;
  logic [PW-1:0]    top_idx;
  logic             has_entry;
  logic             do_push;
  logic             replace_top;
  logic             do_pop;

  assign top_idx     = ptr_q - PW'(1);
  assign has_entry   = (cnt_q != 5'd0);
  assign ras_top     = ras_mem[top_idx];
  assign ret_hit     = ret & has_entry;
  assign do_push     = accept & call;
  assign replace_top = accept & call & ret & has_entry;
  assign do_pop      = accept & ret & ~call & has_entry;
  assign underflow_d = accept & ret & ~has_entry;

  // call+ret with entries rewrites the top in place instead of pop-then-push
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (replace_top) ras_mem[top_idx] <= seq_pc;
      else             ras_mem[ptr_q]   <= seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= 5'd0;
    end else if (exc) begin
      ptr_q <= '0;
      cnt_q <= 5'd0;
    end else if (do_push && !replace_top) begin
      ptr_q <= ptr_q + PW'(1);
      if (cnt_q != 5'(RAS_DEPTH)) cnt_q <= cnt_q + 5'd1;
    end else if (do_pop) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign ras_count = cnt_q;
  assign ras_empty = (cnt_q == 5'd0);
  assign ras_full  = (cnt_q == 5'(RAS_DEPTH));
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = &{1'b0, call, ret};
  assign ret_hit     = 1'b0;
  assign ras_top     = '0;
  assign underflow_d = 1'b0;
  assign ras_count   = 5'd0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
`endif

  always_comb begin
    pc_next = seq_pc;
    if (exc)          pc_next = EXC_VEC;
    else if (load)    pc_next = load_tgt;
    else if (ret_hit) pc_next = ras_top;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VEC;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (exc || enable) pc_q <= pc_next;
      misalign_q  <= accept & load & (|(in & LOW_MASK));
      underflow_q <= underflow_d;
    end
  end

  assign pc            = pc_q;
  assign misalign      = misalign_q;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, load, call, ret, exc;
  logic [31:0] in;
  logic [31:0] pc, pc_next;
  logic [4:0]  ras_count;
  logic        ras_empty, ras_full, misalign, ras_underflow;

  int compared   = 0;
  int mismatched = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .in(in),
    .call(call), .ret(ret), .exc(exc), .pc(pc), .pc_next(pc_next),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .misalign(misalign), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic ld, input logic [31:0] tgt,
                       input logic cl, input logic rt, input logic ex);
    enable = en; load = ld; in = tgt; call = cl; ret = rt; exc = ex;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #12;
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    compared++; if (ras_count !== 5'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", ras_count); end
    compared++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin mismatched++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", ras_empty, ras_full); end
    compared++; if (misalign !== 1'b0 || ras_underflow !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got m=%b u=%b want 0 0", misalign, ras_underflow); end
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      compared++; if (pc !== 32'(4 * i)) begin mismatched++; $display("FAIL seq_%0d got %h want %h", i, pc, 32'(4 * i)); end
    end
    #3 rst = 1'b0;
    #1;
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL async_reset got %h want 0", pc); end
    rst = 1'b1;
  endtask

  task automatic test_stall_exc();
    drive(1, 1, 32'h0C, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0); tick();
    compared++; if (pc !== 32'h10) begin mismatched++; $display("FAIL call_pc got %h want %h", pc, 32'h10); end
    compared++; if (ras_count !== (RAS ? 5'd1 : 5'd0)) begin mismatched++; $display("FAIL call_count got %0d want %0d", ras_count, RAS ? 1 : 0); end
    drive(0, 1, 32'h40, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      compared++; if (pc !== 32'h10) begin mismatched++; $display("FAIL stall_pc_%0d got %h want %h", i, pc, 32'h10); end
      compared++; if (ras_count !== (RAS ? 5'd1 : 5'd0)) begin mismatched++; $display("FAIL stall_count_%0d got %0d want %0d", i, ras_count, RAS ? 1 : 0); end
    end
    drive(0, 0, 0, 0, 0, 1); tick();
    compared++; if (pc !== 32'h80) begin mismatched++; $display("FAIL exc_pc got %h want %h", pc, 32'h80); end
    compared++; if (ras_count !== 5'd0 || ras_empty !== 1'b1) begin mismatched++; $display("FAIL exc_flush got %0d e=%b want 0 e=1", ras_count, ras_empty); end
  endtask

  task automatic test_misalign();
    drive(1, 1, 32'h103, 0, 0, 0); tick();
    compared++; if (pc !== 32'h100) begin mismatched++; $display("FAIL mis_pc got %h want %h", pc, 32'h100); end
    compared++; if (misalign !== 1'b1) begin mismatched++; $display("FAIL mis_pulse got %b want 1", misalign); end
    drive(1, 0, 0, 0, 0, 0); tick();
    compared++; if (pc !== 32'h104 || misalign !== 1'b0) begin mismatched++; $display("FAIL mis_clear got pc=%h m=%b want 104 0", pc, misalign); end
    drive(1, 1, 32'h103, 0, 0, 1); tick();
    compared++; if (pc !== 32'h80 || misalign !== 1'b0) begin mismatched++; $display("FAIL mis_exc got pc=%h m=%b want 80 0", pc, misalign); end
  endtask

  task automatic test_call_ret();
    logic [31:0] exp_pc [5];
    logic [4:0]  exp_cnt [5];
    drive(1, 1, 32'h20, 0, 0, 0); tick();
    exp_pc  = '{32'h200, 32'h204, 32'h300, RAS ? 32'h208 : 32'h304, RAS ? 32'h24 : 32'h308};
    exp_cnt = RAS ? '{5'd1, 5'd1, 5'd2, 5'd1, 5'd0} : '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 1, 32'h200, 1, 0, 0);
        1: drive(1, 0, 0, 0, 0, 0);
        2: drive(1, 1, 32'h300, 1, 0, 0);
        default: drive(1, 0, 0, 0, 1, 0);
      endcase
      tick();
      compared++; if (pc !== exp_pc[i]) begin mismatched++; $display("FAIL cr_pc_%0d got %h want %h", i, pc, exp_pc[i]); end
      compared++; if (ras_count !== exp_cnt[i]) begin mismatched++; $display("FAIL cr_cnt_%0d got %0d want %0d", i, ras_count, exp_cnt[i]); end
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] want;
    drive(1, 1, 32'h1000, 0, 0, 0); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 32'((k + 1) * 32'h1000), 1, 0, 0); tick();
      compared++; if (ras_full !== (RAS && k >= 4)) begin mismatched++; $display("FAIL ovf_full_%0d got %b want %b", k, ras_full, RAS && k >= 4); end
    end
    compared++; if (pc !== 32'h6000) begin mismatched++; $display("FAIL ovf_pc got %h want %h", pc, 32'h6000); end
    for (int r = 1; r <= 5; r++) begin
      drive(1, 0, 0, 0, 1, 0); tick();
      if (!RAS)      want = 32'h6000 + 32'(4 * r);
      else if (r < 5) want = 32'((6 - r) * 32'h1000 + 4);
      else           want = 32'h2008;
      compared++; if (pc !== want) begin mismatched++; $display("FAIL ret_pc_%0d got %h want %h", r, pc, want); end
      compared++; if (ras_underflow !== (RAS && r == 5)) begin mismatched++; $display("FAIL ret_unf_%0d got %b want %b", r, ras_underflow, RAS && r == 5); end
    end
    compared++; if (ras_count !== 5'd0) begin mismatched++; $display("FAIL ret_cnt got %0d want 0", ras_count); end
  endtask

  task automatic test_wrap();
    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    #1;
    compared++; if (pc_next !== 32'h0) begin mismatched++; $display("FAIL wrap_next got %h want 0", pc_next); end
    tick();
    compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL wrap_pc got %h want 0", pc); end
  endtask

  initial begin
    test_reset();
    test_stall_exc();
    test_misalign();
    test_call_ret();
    test_ras_overflow();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; next generation of the fixed 32-bit PC register.
- Selects the next fetch address from exception vector, redirect target, return-address stack (RAS) pop, or sequential increment.
- Sits at the head of the fetch stage. Hazard unit drives `enable` (stall); branch/jump resolution drives `load`, `call` and `ret`; trap logic drives `exc`.
- All state is in this block: PC register, RAS storage, RAS pointer/count and status flags.

Parameters:
- WIDTH, 32, PC width in bits (>= 8).
- STEP, 4, sequential increment; must be a power of two, >= 1.
- RESET_VEC, 0, PC value on reset.
- EXC_VEC, 32'h80, PC value on exception redirect (truncated to WIDTH).
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = PC may advance; 0 = stall (hold).
- load  in  1  redirect to `in` (branch/jump taken).
- in  in  WIDTH  redirect target.
- call  in  1  push return address pc+STEP onto the RAS.
- ret  in  1  pop RAS; top entry becomes the next PC.
- exc  in  1  exception redirect to EXC_VEC; overrides stall.
- pc  out  WIDTH  current PC.
- pc_next  out  WIDTH  combinational next-PC value (valid when an update occurs).
- ras_count  out  5  valid RAS entries, 0..RAS_DEPTH.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- misalign  out  1  registered 1-cycle pulse: a load was accepted with a misaligned target.
- ras_underflow  out  1  registered 1-cycle pulse: a ret was accepted with the RAS empty.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_VEC; ras_count = 0; RAS pointer = 0; misalign = 0; ras_underflow = 0.
  - RAS contents are don't-care after reset.
- An update occurs on a clock edge when exc = 1, or when enable = 1.
- Next-PC priority:
  1. exc: EXC_VEC.
  2. load: `in` with its low log2(STEP) bits cleared.
  3. ret with RAS non-empty: RAS top entry.
  4. Otherwise: pc + STEP, computed modulo 2^WIDTH, so the PC wraps to 0 at the top of the address space.
- Stall: when enable = 0 and exc = 0, pc, RAS, count and both pulse outputs hold (pulses clear to 0). load, call and ret are ignored during a stall.
- Exception:
  - Sets pc to EXC_VEC and clears ras_count to 0 (RAS flush).
  - call and ret are ignored in the same cycle.
- Latency: one cycle from an accepted request to the new pc value.
- RAS push (call accepted, no ret):
  - Writes pc + STEP (the address of the calling instruction + STEP) at the pointer and increments the pointer modulo RAS_DEPTH.
  - ras_count increments, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular).
- RAS pop (ret accepted, no call, count > 0):
  - Next PC is the entry at pointer - 1; pointer decrements; count decrements.
- Pop when empty:
  - Next PC follows the remaining priority (load if asserted, else pc + STEP).
  - ras_underflow pulses; count stays 0.
- call and ret together, count > 0:
  - Next PC is the top entry (unless load is also asserted).
  - The top entry is overwritten with pc + STEP; pointer and count are unchanged.
- call and ret together, count = 0: behaves as an underflowing ret plus a normal push; count becomes 1.
- call + load (direct call): PC goes to `in` and the push still occurs.
- ret + load: load wins for the PC; the RAS pop still occurs.
- misalign pulses when load is accepted (exc = 0) and in[log2(STEP)-1:0] != 0. It never pulses when STEP = 1.

Optional Feature:
- Macro: PC_GEN_RAS_EN.
- Defined:
  - Full RAS behaviour as described above.
- Undefined:
  - No RAS storage is built; ras_count is tied to 0, ras_empty to 1 and ras_full to 0.
  - call is ignored.
  - ret is ignored for PC selection and ras_underflow is tied to 0.
  - All other behaviour is unchanged.

Test Plan:
- Reset then 3 cycles with enable = 1 (WIDTH = 32, STEP = 4): pc = 0 → 4 → 8 → 12. Assert rst = 0 mid-cycle: pc returns to 0 immediately, without waiting for a clock edge.
- pc = 0x10, enable = 0 for 2 cycles with load = 1, in = 0x40: pc holds 0x10. Then exc = 1 with enable = 0: pc = 0x80 next cycle and ras_count = 0.
- load = 1, in = 0x103: pc becomes 0x100 next cycle and misalign pulses for exactly 1 cycle.
- At pc = 0x20, call + load with in = 0x200; then at pc = 0x204, call + load with in = 0x300; then ret twice: pc sequence 0x200, 0x300, 0x208, 0x24, and ras_count sequence 1, 2, 1, 0.
- 5 calls with RAS_DEPTH = 4 (return addresses A1..A5), then 5 rets: rets yield A5, A4, A3, A2 in that order; the 5th ret gives pc + 4 with an ras_underflow pulse. ras_full = 1 after the 4th call.
- pc = 0xFFFF_FFFC, enable = 1, no requests: pc wraps to 0x0000_0000.
